mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit fed directly by the EX/MEM pipeline register.
- Converts the latched ALU address, store data and funct3 into a word-aligned data-memory bus transaction with byte enables.
- Holds the pipeline with mem_stall until the transaction completes.
- Returns sign/zero-extended load data plus misaligned/access-fault exception pulses toward the MEM/WB register and trap logic.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without dmem_ack before access fault; 0 disables timeout.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX/MEM slot holds a valid instruction
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_funct3  input  3  access size/signedness
ex_addr  input  32  byte address (EX/MEM alu_result)
ex_wdata  input  32  store data (EX/MEM mem_write_data)
dmem_req  output  1  bus request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  transaction complete (one-cycle pulse)
dmem_err  input  1  bus error, qualified by dmem_ack
dmem_rdata  input  32  read word, qualified by dmem_ack
mem_stall  output  1  hold IF..EX/MEM this cycle
load_data  output  32  extended load result
load_valid  output  1  load_data valid (one-cycle pulse)
misaligned_exc  output  1  misaligned access pulse
access_fault_exc  output  1  bus error/timeout/illegal-size pulse
exc_addr  output  32  faulting byte address

Behaviour:
- Reset (async, reset_n low): state=IDLE; counter=0.
  - All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, load_valid, exceptions, exc_addr.
  - Reset mid-transaction drops dmem_req immediately. An ack arriving afterwards in IDLE is ignored.
- access = ex_valid & (ex_mem_read | ex_mem_write).
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_stall = access (combinational).
  - No access: stay in IDLE, no outputs.
  - Access, legal and aligned: capture we/addr/be/wdata/funct3 and go to BUSY.
  - Access, misaligned: go to DONE with misaligned_exc and exc_addr=ex_addr. No bus request.
  - Access, illegal funct3 or read&write both set: go to DONE with access_fault_exc. No bus request.
- BUSY:
  - dmem_req=1 with stable captured bus fields; mem_stall=1; counter increments each cycle.
  - dmem_ack & !dmem_err: load → register extended load_data, load_valid; store → no result. Go to DONE.
  - dmem_ack & dmem_err: access_fault_exc, exc_addr. Go to DONE.
  - No ack and counter == TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0): access_fault_exc. Go to DONE. A later ack is ignored.
- DONE:
  - mem_stall=0; result/exception outputs valid for exactly this cycle.
  - Inputs are ignored, since the same instruction is still presented. Go to IDLE unconditionally.
  - counter cleared.
- Result pulses (load_valid, exceptions) are registered, high only in DONE; load_data and exc_addr hold their last value otherwise.
- Latency: aligned access with same-cycle ack takes 3 cycles (IDLE, BUSY, DONE), stall high for 2. Non-memory instructions: 0 stall.
- Alignment and size (a = ex_addr[1:0]):
  - Byte: LB 000, LBU 100, SB 000. Always aligned. be = 4'b0001 << a.
  - Half: LH 001, LHU 101, SH 001. Misaligned if a[0]. be = 4'b0011 << a.
  - Word: LW 010, SW 010. Misaligned if a ≠ 0. be = 4'b1111.
  - Illegal: load funct3 011/110/111; store funct3 ≥ 011.
- Store data:
  - SB: wdata = {4{ex_wdata[7:0]}}.
  - SH: wdata = {2{ex_wdata[15:0]}}.
  - SW: wdata = ex_wdata.
  - For loads, dmem_wdata=0 and dmem_be reflects the access size.
- Load extract:
  - Shift dmem_rdata right by 8*a.
  - LB/LH: sign-extend from bit 7/15. LBU/LHU: zero-extend. LW: raw word.
- dmem_ack/dmem_err outside BUSY are ignored.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111, stall high 3 cycles.
  - DONE: load_valid=1, load_data=0xDEADBEEF.
- LB addr 0x203 with rdata 0x80AABBCC → load_data=0xFFFFFF80, be=1000. LBU same → 0x00000080. LH addr 0x202 → 0xFFFF80AA.
- SB addr 0x101, wdata 0x12345678:
  - dmem_we=1, be=0010, dmem_wdata=0x78787878.
  - SH addr 0x102 → be=1100, dmem_wdata=0x56785678.
- LW at 0x102:
  - No dmem_req; misaligned_exc=1 with exc_addr=0x102 in the next cycle; stall 1 cycle.
  - SH at 0x101 behaves the same way.
- SW with no ack, TIMEOUT_CYCLES=4:
  - access_fault_exc after 5 BUSY cycles (counter 0..4).
  - Separately, ack with dmem_err=1 → access_fault_exc and no load_valid.
- Reset during BUSY:
  - dmem_req drops immediately, all outputs 0.
  - A subsequent stray ack in IDLE produces no output.
  - A back-to-back LW in DONE is not relaunched: exactly one dmem_req episode.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EX/MEM address, store data and funct3
// into a word-aligned bus transaction, stalls the pipeline until the
// transaction completes, and returns extended load data or exception pulses.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned_exc,
  output logic        access_fault_exc,
  output logic [31:0] exc_addr
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [2:0]    r_f3;
  logic [31:0]   r_load_data;
  logic          r_load_valid;
  logic          r_mis;
  logic          r_af;
  logic [31:0]   r_exc_addr;

  logic          w_access;
  logic          w_illegal;
  logic          w_misal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_shift;
  logic [31:0]   w_ld;
  logic          w_busy;

  assign w_access = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_busy   = (r_state == S_BUSY);

  // Decode the incoming access: legality, alignment, byte lanes, store data
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = 32'h0;
    if (ex_mem_read && ex_mem_write)
      w_illegal = 1'b1;
    else if (ex_mem_read)
      w_illegal = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    else
      w_illegal = (ex_funct3 >= 3'b011);
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        w_misal = ex_addr[0];
        w_be    = 4'b0011 << ex_addr[1:0];
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        w_misal = (ex_addr[1:0] != 2'b00);
        w_be    = 4'b1111;
        w_wdata = ex_wdata;
      end
    endcase
    if (!ex_mem_write) w_wdata = 32'h0;
  end

  // Align the returned word to the addressed byte and extend it
  always_comb begin
    w_shift = dmem_rdata >> {r_addr[1:0], 3'b000};
    case (r_f3)
      3'b000:  w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ld = {24'h0, w_shift[7:0]};
      3'b101:  w_ld = {16'h0, w_shift[15:0]};
      default: w_ld = w_shift;
    endcase
  end

  // Transaction FSM; result pulses are registered so they appear only in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_be         <= 4'h0;
      r_wdata      <= 32'h0;
      r_f3         <= 3'h0;
      r_load_data  <= 32'h0;
      r_load_valid <= 1'b0;
      r_mis        <= 1'b0;
      r_af         <= 1'b0;
      r_exc_addr   <= 32'h0;
    end else begin
      r_load_valid <= 1'b0;
      r_mis        <= 1'b0;
      r_af         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              r_af       <= 1'b1;
              r_exc_addr <= ex_addr;
              r_state    <= S_DONE;
            end else if (w_misal) begin
              r_mis      <= 1'b1;
              r_exc_addr <= ex_addr;
              r_state    <= S_DONE;
            end else begin
              r_we    <= ex_mem_write;
              r_addr  <= ex_addr;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_f3    <= ex_funct3;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_ack) begin
            if (dmem_err) begin
              r_af       <= 1'b1;
              r_exc_addr <= r_addr;
            end else if (!r_we) begin
              r_load_data  <= w_ld;
              r_load_valid <= 1'b1;
            end
            r_state <= S_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TMO)) begin
            r_af       <= 1'b1;
            r_exc_addr <= r_addr;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          // Same instruction is still presented here, so it must not relaunch
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus fields are only driven while the request is outstanding
  assign dmem_req         = w_busy;
  assign dmem_we          = w_busy & r_we;
  assign dmem_addr        = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
  assign dmem_be          = w_busy ? r_be : 4'h0;
  assign dmem_wdata       = w_busy ? r_wdata : 32'h0;
  assign mem_stall        = w_busy | ((r_state == S_IDLE) & w_access);
  assign load_data        = r_load_data;
  assign load_valid       = r_load_valid;
  assign misaligned_exc   = r_mis;
  assign access_fault_exc = r_af;
  assign exc_addr         = r_exc_addr;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack, dmem_err;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid, misaligned_exc, access_fault_exc;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;
  int eps    = 0;
  int eps0;
  logic req_prev = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned_exc(misaligned_exc), .access_fault_exc(access_fault_exc),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  // Count request episodes (rising edges of dmem_req seen at clock edges)
  always @(posedge clk) begin
    if (dmem_req && !req_prev) eps = eps + 1;
    req_prev = dmem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  // Load with ack in the first BUSY cycle
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    present(1'b1, 1'b0, f3, a, 32'h0);
    tick();
    chk({tag, "_be"}, 32'(dmem_be), 32'(be));
    chk({tag, "_wd"}, dmem_wdata, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = rd;
    tick();
    dmem_ack = 1'b0; idle_inputs();
    chk({tag, "_lv"}, 32'(load_valid), 32'd1);
    chk({tag, "_ld"}, load_data, exp);
    tick();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    present(1'b0, 1'b1, f3, a, wd);
    tick();
    chk({tag, "_we"}, 32'(dmem_we), 32'd1);
    chk({tag, "_be"}, 32'(dmem_be), 32'(be));
    chk({tag, "_wd"}, dmem_wdata, exp);
    chk({tag, "_adr"}, dmem_addr, {a[31:2], 2'b00});
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; idle_inputs();
    chk({tag, "_nolv"}, 32'(load_valid), 32'd0);
    chk({tag, "_noexc"}, 32'(access_fault_exc | misaligned_exc), 32'd0);
    tick();
  endtask

  task automatic do_bad(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic mis, input logic af);
    present(rd, wr, f3, a, 32'h0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, "_noreq"}, 32'(dmem_req), 32'd0);
    tick();
    idle_inputs();
    chk({tag, "_mis"}, 32'(misaligned_exc), 32'(mis));
    chk({tag, "_af"}, 32'(access_fault_exc), 32'(af));
    chk({tag, "_ea"}, exc_addr, a);
    chk({tag, "_noreq2"}, 32'(dmem_req), 32'd0);
    chk({tag, "_stall2"}, 32'(mem_stall), 32'd0);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; idle_inputs(); ex_funct3 = 3'h0; ex_addr = 32'h0; ex_wdata = 32'h0;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_lv", 32'(load_valid), 32'd0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_ea", exc_addr, 32'h0);
    reset_n = 1'b1;
    tick();

    // LW 0x100, ack in the second BUSY cycle: three stall cycles
    present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_stall1", 32'(mem_stall), 32'd1);
    chk("lw_req_idle", 32'(dmem_req), 32'd0);
    tick();
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", 32'(dmem_be), 32'hF);
    chk("lw_we", 32'(dmem_we), 32'd0);
    chk("lw_stall2", 32'(mem_stall), 32'd1);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    chk("lw_stall3", 32'(mem_stall), 32'd1);
    tick();
    dmem_ack = 1'b0;
    chk("lw_lv", 32'(load_valid), 32'd1);
    chk("lw_ld", load_data, 32'hDEADBEEF);
    chk("lw_stall_done", 32'(mem_stall), 32'd0);
    chk("lw_req_done", 32'(dmem_req), 32'd0);
    idle_inputs();
    tick();
    chk("lw_lv_off", 32'(load_valid), 32'd0);
    chk("lw_ld_hold", load_data, 32'hDEADBEEF);

    do_load("lb", 3'b000, 32'h203, 32'h80AABBCC, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80AABBCC, 4'b1000, 32'h00000080);
    do_load("lh", 3'b001, 32'h202, 32'h80AABBCC, 4'b1100, 32'hFFFF80AA);
    do_load("lhu", 3'b101, 32'h200, 32'h1234F00D, 4'b0011, 32'h0000F00D);

    do_store("sb", 3'b000, 32'h101, 32'h12345678, 4'b0010, 32'h78787878);
    do_store("sh", 3'b001, 32'h102, 32'h12345678, 4'b1100, 32'h56785678);
    do_store("sw", 3'b010, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    do_bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 1'b1, 1'b0);
    do_bad("sh_mis", 1'b0, 1'b1, 3'b001, 32'h101, 1'b1, 1'b0);
    do_bad("ld_ill", 1'b1, 1'b0, 3'b011, 32'h108, 1'b0, 1'b1);
    do_bad("st_ill", 1'b0, 1'b1, 3'b100, 32'h10C, 1'b0, 1'b1);
    do_bad("rw_ill", 1'b1, 1'b1, 3'b010, 32'h110, 1'b0, 1'b1);

    // SW with no ack: fault after five BUSY cycles
    present(1'b0, 1'b1, 3'b010, 32'h300, 32'h11111111);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tmo_req%0d", i), 32'(dmem_req), 32'd1);
      chk($sformatf("tmo_af%0d", i), 32'(access_fault_exc), 32'd0);
      tick();
    end
    idle_inputs();
    chk("tmo_af", 32'(access_fault_exc), 32'd1);
    chk("tmo_ea", exc_addr, 32'h300);
    chk("tmo_req_off", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b1;
    tick();
    tick();
    dmem_ack = 1'b0;
    chk("tmo_late_af", 32'(access_fault_exc), 32'd0);
    chk("tmo_late_lv", 32'(load_valid), 32'd0);

    // Bus error on a load
    present(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    dmem_ack = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0; dmem_err = 1'b0; idle_inputs();
    chk("err_af", 32'(access_fault_exc), 32'd1);
    chk("err_lv", 32'(load_valid), 32'd0);
    chk("err_ea", exc_addr, 32'h400);
    chk("err_ld_hold", load_data, 32'h0000F00D);
    tick();

    // Reset in BUSY drops the request at once
    present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    chk("rb_req", 32'(dmem_req), 32'd1);
    #2;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk("rb_req_off", 32'(dmem_req), 32'd0);
    chk("rb_addr", dmem_addr, 32'h0);
    chk("rb_ld", load_data, 32'h0);
    chk("rb_ea", exc_addr, 32'h0);
    chk("rb_stall", 32'(mem_stall), 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    tick();
    dmem_ack = 1'b0;
    chk("stray_lv", 32'(load_valid), 32'd0);
    chk("stray_af", 32'(access_fault_exc), 32'd0);
    chk("stray_req", 32'(dmem_req), 32'd0);
    chk("stray_stall", 32'(mem_stall), 32'd0);

    // LW held through DONE must produce exactly one request episode
    eps0 = eps;
    present(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADCAFE;
    tick();
    dmem_ack = 1'b0;
    chk("b2b_lv", 32'(load_valid), 32'd1);
    chk("b2b_ld", load_data, 32'h0BADCAFE);
    tick();
    idle_inputs();
    chk("b2b_req_idle", 32'(dmem_req), 32'd0);
    tick(); tick(); tick();
    chk("b2b_eps", 32'(eps - eps0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
